pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Centralised, parametrised stall/flush/valid controller for the in-order core pipeline. It replaces the scattered per-register stall and flush wiring with one unit. The unit arbitrates fetch wait, load-use hazards, data-bus wait and control-flow redirects, and drives every pipeline register and the PC. It tracks per-stage valid bits, produces the retire strobe, and holds cycle, retire and stall performance counters.

Parameters:
STAGES, 5, number of pipeline stages (stage 0 = IF).
HAZ_STAGE, 1, stage that detects load-use hazards.
REDIR_STAGE, 1, stage that resolves branches/jumps.
MEM_STAGE, 3, stage that waits on the data bus.
CNT_WIDTH, 32, performance counter width.
Legal set: 1 <= HAZ_STAGE <= MEM_STAGE < STAGES-1 and 1 <= REDIR_STAGE <= MEM_STAGE. Elaboration error otherwise.

Ports:
i_Clock  in  1  clock
i_Reset  in  1  reset, synchronous, active-low
i_IFetchBusy  in  1  instruction bus has no instruction this cycle
i_DataBusy  in  1  data bus access in MEM_STAGE not complete
i_Hazard  in  1  load-use hazard at HAZ_STAGE
i_Redirect  in  1  taken branch/jump at REDIR_STAGE
i_CountClear  in  1  synchronous clear of all counters
o_Stall  out  STAGES  bit s: stage s pipeline register holds
o_Flush  out  STAGES  bit s: register feeding stage s loads a bubble (bit 0 always 0)
o_Valid  out  STAGES  bit s: stage s holds a real instruction
o_PCEnable  out  1  PC register loads next/redirect address
o_RedirectAck  out  1  redirect accepted this cycle
o_Retire  out  1  instruction completes in last stage
o_CycleCount  out  CNT_WIDTH  cycles since reset/clear
o_RetireCount  out  CNT_WIDTH  retired instructions
o_StallCount  out  CNT_WIDTH  cycles with any stall

Behaviour:
- Reset (i_Reset=0 at a clock edge): valid bits, internal run flag and all counters go to 0. While reset is held, o_Stall, o_Flush, o_PCEnable, o_RedirectAck and o_Retire are forced to 0. Reset mid-stall or mid-redirect discards all state; no pending event survives.
- Run flag: set on the first edge after reset release.
- Stage 0 valid is combinational: o_Valid[0] = run & !i_IFetchBusy.
- Hold boundary h (combinational, priority order):
  - MEM_STAGE if i_DataBusy;
  - else HAZ_STAGE if i_Hazard;
  - else 0 if i_IFetchBusy;
  - else none.
- Stall: o_Stall[s] = 1 for s <= h. Stages above h advance.
- Bubble: o_Flush[h+1] = 1, so the hold boundary injects a bubble.
- The last stage never stalls.
- Redirect accepted: o_RedirectAck = i_Redirect & o_Valid[REDIR_STAGE] & !o_Stall[REDIR_STAGE].
  - Any redirect that is not accepted is ignored, not queued. The requester re-presents it, since its stage is held.
  - On acceptance: o_Flush[s] = 1 for 1 <= s <= REDIR_STAGE, squashing wrong-path instructions.
  - On acceptance: o_PCEnable = 1, even with i_IFetchBusy. The IF stage abandons the in-flight fetch.
- o_PCEnable = run & (!o_Stall[0] | o_RedirectAck).
- Valid registers, s >= 1, updated on each edge:
  - hold if o_Stall[s];
  - else 0 if o_Flush[s];
  - else o_Valid[s-1].
- o_Retire = o_Valid[STAGES-1], combinational.
- Counters (while run):
  - cycle counter increments every cycle;
  - retire counter increments on o_Retire;
  - stall counter increments when h exists.
  - All counters wrap modulo 2^CNT_WIDTH.
  - i_CountClear wins over a simultaneous increment (result 0).
- Latency: all control outputs are combinational from inputs and valid state. Valid state changes take effect one cycle later.

Decomposition:
- Types package: stage index constants STAGE_IF/ID/EX/MEM/WB, used as parameter defaults, and a typedef for the hold-boundary encoding (none or stage index).
- One sub-module, perf_counter (CNT_WIDTH; enable, clear, value), instantiated three times.

Test Plan:
All scenarios use the defaults (STAGES=5, HAZ=1, REDIR=1, MEM=3).
1. i_Reset=0 for 3 cycles, then 1, no events:
   - During reset: all outputs 0.
   - o_Valid goes 00001, 00011, … 11111.
   - o_Retire first 1 on the 5th cycle after release.
   - o_RetireCount=1 one cycle later.
2. Full pipe, i_Hazard for 1 cycle:
   - o_Stall=00011, o_Flush=00100, o_PCEnable=0.
   - Next cycle o_Valid=11011; o_StallCount +1.
3. Full pipe, i_DataBusy for 3 cycles:
   - o_Stall=01111, o_Flush=10000.
   - o_Retire=0 on cycles 2-4, o_StallCount +3.
   - i_Redirect during the wait: o_RedirectAck=0.
4. i_Redirect with o_Valid[1]=1:
   - o_RedirectAck=1, o_Flush=00010, o_PCEnable=1; next o_Valid[1]=0.
   - Repeat with i_Hazard=1: ack 0, PCEnable 0.
   - Repeat with o_Valid[1]=0: ack 0.
5. i_IFetchBusy together with i_Redirect:
   - o_Stall=00001, o_PCEnable=1, o_RedirectAck=1, o_Flush=00010.
6. CNT_WIDTH=4, run 16 cycles:
   - o_CycleCount wraps to 0.
   - i_CountClear asserted with a retire pending: all counters read 0 next cycle.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline controller: stage indices and hold-boundary encoding.
package pipeline_ctrl_pkg;

    localparam int unsigned STAGE_IF  = 0;
    localparam int unsigned STAGE_ID  = 1;
    localparam int unsigned STAGE_EX  = 2;
    localparam int unsigned STAGE_MEM = 3;
    localparam int unsigned STAGE_WB  = 4;

    localparam int unsigned HOLD_IDX_W = 8;

    // Hold boundary: either no stage holds, or stages 0..idx hold.
    typedef struct packed {
        logic                  active;
        logic [HOLD_IDX_W-1:0] idx;
    } hold_t;

    localparam hold_t HOLD_NONE = '{active: 1'b0, idx: '0};

    function automatic hold_t hold_at(input int unsigned stage);
        hold_t h;
        h.active = 1'b1;
        h.idx    = HOLD_IDX_W'(stage);
        return h;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// Wrapping performance counter with synchronous active-low reset and clear.
module perf_counter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] value_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Clear dominates a simultaneous increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush/valid controller for the in-order pipeline, with perf counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned STAGES      = STAGE_WB + 1,
    parameter int unsigned HAZ_STAGE   = STAGE_ID,
    parameter int unsigned REDIR_STAGE = STAGE_ID,
    parameter int unsigned MEM_STAGE   = STAGE_MEM,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_IFetchBusy,
    input  logic                 i_DataBusy,
    input  logic                 i_Hazard,
    input  logic                 i_Redirect,
    input  logic                 i_CountClear,
    output logic [STAGES-1:0]    o_Stall,
    output logic [STAGES-1:0]    o_Flush,
    output logic [STAGES-1:0]    o_Valid,
    output logic                 o_PCEnable,
    output logic                 o_RedirectAck,
    output logic                 o_Retire,
    output logic [CNT_WIDTH-1:0] o_CycleCount,
    output logic [CNT_WIDTH-1:0] o_RetireCount,
    output logic [CNT_WIDTH-1:0] o_StallCount
);

    if (!(HAZ_STAGE >= 1 && HAZ_STAGE <= MEM_STAGE && MEM_STAGE < STAGES - 1 &&
          REDIR_STAGE >= 1 && REDIR_STAGE <= MEM_STAGE && STAGES <= 256)) begin : g_param_check
        $error("pipeline_ctrl: illegal stage parameters");
    end

    logic              run_q;
    logic [STAGES-1:1] valid_q, valid_d;
    logic [STAGES-1:0] valid, stall, flush;
    logic              ack, pc_en, retire;
    hold_t             hold;

    assign valid[STAGE_IF]     = run_q & ~i_IFetchBusy;
    assign valid[STAGES-1:1]   = valid_q;

    always_comb begin
        hold = HOLD_NONE;
        if (i_DataBusy) begin
            hold = hold_at(MEM_STAGE);
        end else if (i_Hazard) begin
            hold = hold_at(HAZ_STAGE);
        end else if (i_IFetchBusy) begin
            hold = hold_at(STAGE_IF);
        end
    end

    // The last stage is excluded: it always drains.
    always_comb begin
        stall = '0;
        for (int unsigned s = 0; s < STAGES - 1; s++) begin
            if (hold.active && HOLD_IDX_W'(s) <= hold.idx) begin
                stall[s] = 1'b1;
            end
        end
    end

    assign ack = i_Redirect & valid[REDIR_STAGE] & ~stall[REDIR_STAGE];

    always_comb begin
        flush = '0;
        for (int unsigned s = 1; s < STAGES; s++) begin
            if (hold.active && HOLD_IDX_W'(s) == hold.idx + HOLD_IDX_W'(1)) begin
                flush[s] = 1'b1;
            end
            if (ack && s <= REDIR_STAGE) begin
                flush[s] = 1'b1;
            end
        end
    end

    // A redirect overrides an IF hold: the in-flight fetch is abandoned.
    assign pc_en  = run_q & (~stall[STAGE_IF] | ack);
    assign retire = valid[STAGES-1];

    always_comb begin
        valid_d = valid_q;
        for (int unsigned s = 1; s < STAGES; s++) begin
            if (stall[s]) begin
                valid_d[s] = valid_q[s];
            end else if (flush[s]) begin
                valid_d[s] = 1'b0;
            end else begin
                valid_d[s] = valid[s-1];
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            run_q   <= 1'b0;
            valid_q <= '0;
        end else begin
            run_q   <= 1'b1;
            valid_q <= valid_d;
        end
    end

    assign o_Stall       = i_Reset ? stall  : '0;
    assign o_Flush       = i_Reset ? flush  : '0;
    assign o_PCEnable    = i_Reset & pc_en;
    assign o_RedirectAck = i_Reset & ack;
    assign o_Retire      = i_Reset & retire;
    assign o_Valid       = valid;

    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk_i   (i_Clock),
        .rst_ni  (i_Reset),
        .en_i    (run_q),
        .clr_i   (i_CountClear),
        .value_o (o_CycleCount)
    );

    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_retire_cnt (
        .clk_i   (i_Clock),
        .rst_ni  (i_Reset),
        .en_i    (run_q & retire),
        .clr_i   (i_CountClear),
        .value_o (o_RetireCount)
    );

    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk_i   (i_Clock),
        .rst_ni  (i_Reset),
        .en_i    (run_q & hold.active),
        .clr_i   (i_CountClear),
        .value_o (o_StallCount)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed, table-driven bench for pipeline_ctrl (default parameters plus a 4-bit counter copy).
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst, ifb, db, hz, rd, clr;

    logic [4:0]  stall, flush, valid;
    logic        pcen, ack, retire;
    logic [31:0] cc, rc, sc;

    logic [4:0]  stall4, flush4, valid4;
    logic        pcen4, ack4, retire4;
    logic [3:0]  cc4, rc4, sc4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .i_Clock(clk), .i_Reset(rst), .i_IFetchBusy(ifb), .i_DataBusy(db),
        .i_Hazard(hz), .i_Redirect(rd), .i_CountClear(clr),
        .o_Stall(stall), .o_Flush(flush), .o_Valid(valid), .o_PCEnable(pcen),
        .o_RedirectAck(ack), .o_Retire(retire),
        .o_CycleCount(cc), .o_RetireCount(rc), .o_StallCount(sc)
    );

    pipeline_ctrl #(.CNT_WIDTH(4)) dut4 (
        .i_Clock(clk), .i_Reset(rst), .i_IFetchBusy(ifb), .i_DataBusy(db),
        .i_Hazard(hz), .i_Redirect(rd), .i_CountClear(clr),
        .o_Stall(stall4), .o_Flush(flush4), .o_Valid(valid4), .o_PCEnable(pcen4),
        .o_RedirectAck(ack4), .o_Retire(retire4),
        .o_CycleCount(cc4), .o_RetireCount(rc4), .o_StallCount(sc4)
    );

    typedef struct {
        logic       ifb, db, hz, rd;
        logic [4:0] valid, stall, flush;
        logic       pcen, ack, retire;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctrl_zero(input string tag);
        chk({tag, " stall"}, 64'(stall), 64'd0);
        chk({tag, " flush"}, 64'(flush), 64'd0);
        chk({tag, " pcen"}, 64'(pcen), 64'd0);
        chk({tag, " ack"}, 64'(ack), 64'd0);
        chk({tag, " retire"}, 64'(retire), 64'd0);
    endtask

    initial begin
        // ifb db hz rd | valid stall flush | pcen ack retire
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b11111, 5'b00011, 5'b00100, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b11011, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b10111, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b01111, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b11111, 5'b01111, 5'b10000, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'b01111, 5'b01111, 5'b10000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b01111, 5'b01111, 5'b10000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b01111, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b11111, 5'b00000, 5'b00010, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b11101, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'b11011, 5'b00011, 5'b00100, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b10010, 5'b00001, 5'b00010, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00101, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b01010, 5'b00001, 5'b00010, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b10101, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b1};

        rst = 1'b0; ifb = 1'b0; db = 1'b0; hz = 1'b0; rd = 1'b0; clr = 1'b0;

        // Reset held with events pending: everything stays quiet.
        step();
        db = 1'b1; hz = 1'b1; rd = 1'b1;
        #1;
        chk_ctrl_zero("reset1");
        chk("reset1 valid", 64'(valid), 64'd0);
        step();
        step();
        chk_ctrl_zero("reset3");
        chk("reset3 valid", 64'(valid), 64'd0);
        chk("reset3 cc", 64'(cc), 64'd0);
        chk("reset3 rc", 64'(rc), 64'd0);
        chk("reset3 sc", 64'(sc), 64'd0);

        // Pipe fill after release.
        db = 1'b0; hz = 1'b0; rd = 1'b0; rst = 1'b1;
        step();
        chk("fill0 valid", 64'(valid), 64'b00001);
        chk("fill0 pcen", 64'(pcen), 64'd1);
        chk("fill0 cc", 64'(cc), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("fill%0d valid", k), 64'(valid), 64'((1 << (k + 1)) - 1));
            chk($sformatf("fill%0d retire", k), 64'(retire), 64'(k == 4));
        end
        step();
        chk("fill rc", 64'(rc), 64'd1);
        chk("fill cc", 64'(cc), 64'd5);

        for (int i = 0; i < 15; i++) begin
            ifb = vecs[i].ifb; db = vecs[i].db; hz = vecs[i].hz; rd = vecs[i].rd;
            #1;
            chk($sformatf("v%0d valid", i), 64'(valid), 64'(vecs[i].valid));
            chk($sformatf("v%0d stall", i), 64'(stall), 64'(vecs[i].stall));
            chk($sformatf("v%0d flush", i), 64'(flush), 64'(vecs[i].flush));
            chk($sformatf("v%0d pcen", i), 64'(pcen), 64'(vecs[i].pcen));
            chk($sformatf("v%0d ack", i), 64'(ack), 64'(vecs[i].ack));
            chk($sformatf("v%0d retire", i), 64'(retire), 64'(vecs[i].retire));
            step();
        end
        ifb = 1'b0; db = 1'b0; hz = 1'b0; rd = 1'b0;
        #1;
        chk("table cc", 64'(cc), 64'd20);
        chk("table rc", 64'(rc), 64'd10);
        chk("table sc", 64'(sc), 64'd7);
        chk("table cc4", 64'(cc4), 64'd4);

        // Reset in the middle of a data wait and redirect.
        db = 1'b1; rd = 1'b1; hz = 1'b1; rst = 1'b0;
        #1;
        chk_ctrl_zero("midrst");
        step();
        chk("midrst valid", 64'(valid), 64'd0);
        chk("midrst cc", 64'(cc), 64'd0);
        chk("midrst sc", 64'(sc), 64'd0);
        db = 1'b0; rd = 1'b0; hz = 1'b0; rst = 1'b1;
        step();
        chk("rel valid", 64'(valid), 64'b00001);
        chk("rel ack", 64'(ack), 64'd0);
        chk("rel rc", 64'(rc), 64'd0);

        // 16 more cycles: the 4-bit cycle counter wraps to 0.
        for (int k = 0; k < 16; k++) step();
        chk("wrap cc", 64'(cc), 64'd16);
        chk("wrap cc4", 64'(cc4), 64'd0);
        chk("wrap rc", 64'(rc), 64'd12);
        chk("wrap rc4", 64'(rc4), 64'd12);
        chk("wrap sc", 64'(sc), 64'd0);

        // Clear with a retire pending wins over the increment.
        chk("clr retire", 64'(retire), 64'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr cc", 64'(cc), 64'd0);
        chk("clr rc", 64'(rc), 64'd0);
        chk("clr sc", 64'(sc), 64'd0);
        chk("clr cc4", 64'(cc4), 64'd0);
        chk("clr rc4", 64'(rc4), 64'd0);
        step();
        chk("post clr cc", 64'(cc), 64'd1);
        chk("post clr rc", 64'(rc), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
